// File: rtl/ex_stage_buf.sv
// Execute stage: combinational ALU feeding a 2-entry FIFO skid buffer with valid/ready on both sides.
// Optional signed-overflow detection for ADD/SUB is enabled by defining ALU_OVERFLOW_EN.
module ex_stage_buf #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_aluctrl,
   input  logic [DATA_W-1:0] in_srca,
   input  logic [DATA_W-1:0] in_srcb,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_regwrite,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_regwrite,
   output logic              out_overflow
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              overflow;
   } entry_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              in_ready_q, in_ready_d;
   logic              push, pop;

   logic              is_sub;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W-1:0] addsub;
   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   entry_t            new_entry;
   entry_t            head;

   // ADD and SUB share one adder; SUB is a + ~b + 1.
   assign is_sub = (in_aluctrl == OP_SUB);
   assign b_eff  = is_sub ? ~in_srcb : in_srcb;
   assign addsub = in_srca + b_eff + {{(DATA_W-1){1'b0}}, is_sub};

   always_comb begin
      alu_res = '0;
      case (in_aluctrl)
         OP_AND:  alu_res = in_srca & in_srcb;
         OP_OR:   alu_res = in_srca | in_srcb;
         OP_ADD:  alu_res = addsub;
         OP_SUB:  alu_res = addsub;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(in_srca) < $signed(in_srcb))};
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   assign alu_ovf = ((in_aluctrl == OP_ADD) || is_sub)
                    && (in_srca[DATA_W-1] == b_eff[DATA_W-1])
                    && (addsub[DATA_W-1] != in_srca[DATA_W-1]);
`else
   assign alu_ovf = 1'b0;
`endif

   // A trapping add/sub must not write back.
   always_comb begin
      new_entry          = '0;
      new_entry.result   = alu_res;
      new_entry.zero     = (alu_res == '0);
      new_entry.rd       = in_rd;
      new_entry.regwrite = in_regwrite & ~alu_ovf;
      new_entry.overflow = alu_ovf;
   end

   assign push = in_valid & in_ready_q & ~flush;
   assign pop  = (count_q != 2'd0) & out_ready & ~flush;

   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      in_ready_d = in_ready_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_ready_q <= in_ready_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      entry_t ent_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ent_q <= '0;
         end else if (push && (wr_ptr_q == 1'(gi))) begin
            ent_q <= new_entry;
         end
      end
   end

   assign head = rd_ptr_q ? g_entry[1].ent_q : g_entry[0].ent_q;

   // Outputs are forced to zero whenever the buffer is empty.
   assign in_ready     = in_ready_q;
   assign out_valid    = (count_q != 2'd0);
   assign out_result   = out_valid ? head.result   : '0;
   assign out_zero     = out_valid ? head.zero     : 1'b0;
   assign out_rd       = out_valid ? head.rd       : '0;
   assign out_regwrite = out_valid ? head.regwrite : 1'b0;
   assign out_overflow = out_valid ? head.overflow : 1'b0;

endmodule
